// File: rtl/rf_wb_arbiter.sv
// Round-robin write-port arbiter for the register file: one grant per cycle,
// with the winner's address/data registered onto the write port.
module rf_wb_arbiter #(
    parameter int unsigned NSRC = 3,
    parameter int unsigned DW   = 32,
    parameter int unsigned AW   = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NSRC-1:0]    src_valid,
    output logic [NSRC-1:0]    src_ready,
    input  logic [NSRC*AW-1:0] src_addr,
    input  logic [NSRC*DW-1:0] src_data,
    output logic               rf_we,
    output logic [AW-1:0]      rf_waddr,
    output logic [DW-1:0]      rf_wdata,
    output logic [2:0]         grant_id
);

    logic [2:0]    r_ptr;
    logic          r_we;
    logic [AW-1:0] r_waddr;
    logic [DW-1:0] r_wdata;
    logic [2:0]    r_gid;

    logic [7:0]    w_valid;
    logic [3:0]    w_idx;
    logic          w_found;
    logic          w_xfer;
    logic [2:0]    w_win;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_data;

    // Scan from the pointer upward, wrapping modulo NSRC; first valid source wins.
    always_comb begin
        w_valid = 8'(src_valid);
        w_idx   = '0;
        w_found = 1'b0;
        w_win   = '0;
        for (int unsigned k = 0; k < NSRC; k++) begin
            w_idx = 4'(r_ptr) + 4'(k);
            if (w_idx >= 4'(NSRC)) begin
                w_idx = w_idx - 4'(NSRC);
            end
            if (!w_found && w_valid[w_idx[2:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[2:0];
            end
        end
    end

    // Grants are suppressed while reset is asserted so no transfer can be signalled.
    assign w_xfer = w_found & rst_n;

    always_comb begin
        w_addr    = '0;
        w_data    = '0;
        src_ready = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (3'(i) == w_win) begin
                w_addr       = src_addr[i*AW +: AW];
                w_data       = src_data[i*DW +: DW];
                src_ready[i] = w_xfer;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr   <= '0;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_gid   <= '0;
        end else begin
            // Register-0 writes still release the requester but never raise the enable.
            r_we <= w_xfer && (w_addr != '0);
            if (w_xfer) begin
                r_waddr <= w_addr;
                r_wdata <= w_data;
                r_gid   <= w_win;
                r_ptr   <= (w_win == 3'(NSRC - 1)) ? '0 : w_win + 3'd1;
            end
        end
    end

    assign rf_we    = r_we;
    assign rf_waddr = r_waddr;
    assign rf_wdata = r_wdata;
    assign grant_id = r_gid;

endmodule
